// File: rtl/mat_inv_pkg.sv
// rtl/mat_inv_pkg.sv - shared types and constants for the matrix-inversion column sequencer
package mat_inv_pkg;

    localparam int PKG_MAT_SIZE = 4;
    localparam int PKG_DATWIDTH = 64;

    // Nominal normaliser latency (inputReady cycle to outVld cycle), used by benches
    localparam int NORM_LATENCY = 37;

    typedef logic [PKG_DATWIDTH-1:0] col_t [PKG_MAT_SIZE];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/mat_col_bank.sv
// rtl/mat_col_bank.sv - MAT_SIZE-column register bank, one write port, two combinational read ports
module mat_col_bank #(
    parameter int MAT_SIZE = 4,
    parameter int DATWIDTH = 64,
    parameter int CW       = $clog2(MAT_SIZE) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_idx,
    input  logic [DATWIDTH-1:0] wr_data [MAT_SIZE],
    input  logic [CW-1:0]       rd_a_idx,
    output logic [DATWIDTH-1:0] rd_a_data [MAT_SIZE],
    input  logic [CW-1:0]       rd_b_idx,
    output logic [DATWIDTH-1:0] rd_b_data [MAT_SIZE]
);

    logic [DATWIDTH-1:0] bank [MAT_SIZE][MAT_SIZE];

    // Index decode by compare so out-of-range indices simply match nothing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAT_SIZE; i++) begin
                bank[i] <= '{default: '0};
            end
        end else begin
            for (int i = 0; i < MAT_SIZE; i++) begin
                if (wr_en && (wr_idx == CW'(i))) begin
                    bank[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_a_data = '{default: '0};
        rd_b_data = '{default: '0};
        for (int i = 0; i < MAT_SIZE; i++) begin
            if (rd_a_idx == CW'(i)) rd_a_data = bank[i];
            if (rd_b_idx == CW'(i)) rd_b_data = bank[i];
        end
    end

endmodule

// File: rtl/mat_column_sequencer.sv
// rtl/mat_column_sequencer.sv - issues bank columns to the normaliser and writes results back; optional WAIT watchdog under MAT_SEQ_TIMEOUT_EN
module mat_column_sequencer
    import mat_inv_pkg::*;
#(
    parameter int  MAT_SIZE       = 4,
    parameter int  DATWIDTH       = 64,
    parameter int  TIMEOUT_CYCLES = 64,
    localparam int CW             = $clog2(MAT_SIZE) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_vld,
    input  logic [CW-1:0]       load_col,
    input  logic [DATWIDTH-1:0] load_data [MAT_SIZE],
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                inputReady,
    output logic [CW-1:0]       opCnt,
    output logic [DATWIDTH-1:0] opColumn [MAT_SIZE],
    input  logic                outVld,
    input  logic [DATWIDTH-1:0] opColumnNorm [MAT_SIZE],
    input  logic [CW-1:0]       rd_col,
    output logic [DATWIDTH-1:0] rd_data [MAT_SIZE],
    output logic                err_timeout
);

    seq_state_e          state_q, state_d;
    logic [CW-1:0]       opcnt_q, opcnt_d, issue_idx;
    logic                issue_ld;
    logic                wr_en;
    logic [CW-1:0]       wr_idx;
    logic [DATWIDTH-1:0] wr_data    [MAT_SIZE];
    logic [DATWIDTH-1:0] bank_issue [MAT_SIZE];
    logic [DATWIDTH-1:0] opcol_q    [MAT_SIZE];
    logic                timeout_hit;

    mat_col_bank #(
        .MAT_SIZE (MAT_SIZE),
        .DATWIDTH (DATWIDTH),
        .CW       (CW)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .rd_a_idx  (issue_idx),
        .rd_a_data (bank_issue),
        .rd_b_idx  (rd_col),
        .rd_b_data (rd_data)
    );

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = load_col;
        wr_data = load_data;
        if (state_q == ST_IDLE && load_vld) begin
            wr_en = 1'b1;
        end else if (state_q == ST_WAIT && outVld) begin
            wr_en   = 1'b1;
            wr_idx  = opcnt_q;
            wr_data = opColumnNorm;
        end
    end

    always_comb begin
        state_d   = state_q;
        opcnt_d   = opcnt_q;
        issue_ld  = 1'b0;
        issue_idx = opcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_ISSUE;
                    opcnt_d   = '0;
                    issue_ld  = 1'b1;
                    issue_idx = '0;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (outVld) begin
                    if (opcnt_q == CW'(MAT_SIZE - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_ISSUE;
                        opcnt_d   = opcnt_q + 1'b1;
                        issue_ld  = 1'b1;
                        issue_idx = opcnt_q + 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            opcnt_q <= '0;
            opcol_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            opcnt_q <= opcnt_d;
            // Forward a same-cycle bank write so ISSUE sees a load that coincides with start
            if (issue_ld) begin
                for (int e = 0; e < MAT_SIZE; e++) begin
                    opcol_q[e] <= (wr_en && wr_idx == issue_idx) ? wr_data[e] : bank_issue[e];
                end
            end
        end
    end

`ifdef MAT_SEQ_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_q;
    logic           err_q;

    assign timeout_hit = (state_q == ST_WAIT) && (wd_q == WDW'(TIMEOUT_CYCLES - 1));

    // WAIT is only entered from ISSUE, so clearing in ISSUE restarts the count per column
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == ST_ISSUE)     wd_q <= '0;
            else if (state_q == ST_WAIT) wd_q <= wd_q + 1'b1;
            if (state_q == ST_IDLE && start)  err_q <= 1'b0;
            else if (timeout_hit && !outVld)  err_q <= 1'b1;
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign done       = (state_q == ST_DONE);
    assign inputReady = (state_q == ST_ISSUE);
    assign opCnt      = opcnt_q;
    assign opColumn   = opcol_q;

endmodule

// File: tb/tb_mat_column_sequencer.sv
// tb/tb_mat_column_sequencer.sv - directed self-checking bench for mat_column_sequencer
module tb_mat_column_sequencer;
    import mat_inv_pkg::*;

    localparam int MS = 4;
    localparam int DW = 64;
    localparam int CW = $clog2(MS) + 1;
    localparam int L  = NORM_LATENCY;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_vld;
    logic [CW-1:0] load_col;
    col_t          load_data;
    logic          start;
    logic          busy, done, inputReady, err_timeout;
    logic [CW-1:0] opCnt;
    col_t          opColumn;
    logic          outVld;
    col_t          opColumnNorm;
    logic [CW-1:0] rd_col;
    col_t          rd_data;

    mat_column_sequencer #(.MAT_SIZE(MS), .DATWIDTH(DW), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset), .load_vld(load_vld), .load_col(load_col),
        .load_data(load_data), .start(start), .busy(busy), .done(done),
        .inputReady(inputReady), .opCnt(opCnt), .opColumn(opColumn),
        .outVld(outVld), .opColumnNorm(opColumnNorm), .rd_col(rd_col),
        .rd_data(rd_data), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // Normaliser model: returns ~opColumn L cycles after the inputReady cycle
    logic model_vld, inj_vld;
    col_t model_norm, inj_norm, m_held;
    int   m_cnt = 0;
    int   drop_col = -1;
    int   slow_col = -1;
    int   slow_extra = 0;

    assign outVld = model_vld | inj_vld;
    always_comb begin
        for (int e = 0; e < MS; e++) opColumnNorm[e] = inj_vld ? inj_norm[e] : model_norm[e];
    end

    initial begin
        model_vld  = 1'b0;
        model_norm = '{default: '0};
        forever begin
            @(posedge clk); #1;
            model_vld = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    model_vld = 1'b1;
                    for (int e = 0; e < MS; e++) model_norm[e] = ~m_held[e];
                end
            end else if (inputReady && int'(opCnt) != drop_col) begin
                m_held = opColumn;
                m_cnt  = L + ((int'(opCnt) == slow_col) ? slow_extra : 0);
            end
        end
    end

    typedef struct {
        int          col;
        logic [63:0] base;
        int          exp_issue;
    } vec_t;
    vec_t tbl[5];

    int   issue_rel[8];
    int   issue_cnt[8];
    col_t issue_col[8];
    int   n_issue, n_done, done_rel, busy_first, busy_last, err_rel;
    logic [63:0] snap_rd0;
    logic snap_busy, snap_ir;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_col(input string name, input col_t act, input col_t exp);
        for (int e = 0; e < MS; e++) chk($sformatf("%s[%0d]", name, e), act[e], exp[e]);
    endtask

    task automatic read_col(input int c, output col_t v);
        rd_col = CW'(c);
        #1;
        v = rd_data;
    endtask

    // Drives start in the current cycle (rel 0) and observes ncyc further cycles
    task automatic run_pass(input int ncyc, input int start2_at, input int inj_at);
        int t0, rel;
        n_issue = 0; n_done = 0; done_rel = -1; busy_first = -1; busy_last = -1; err_rel = -1;
        start = 1'b1;
        t0 = cyc;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            start = 1'b0; load_vld = 1'b0; inj_vld = 1'b0;
            rel = cyc - t0;
            if (inputReady) begin
                if (n_issue < 8) begin
                    issue_rel[n_issue] = rel;
                    issue_cnt[n_issue] = int'(opCnt);
                    issue_col[n_issue] = opColumn;
                end
                n_issue++;
            end
            if (done) begin n_done++; done_rel = rel; end
            if (busy) begin
                if (busy_first < 0) busy_first = rel;
                busy_last = rel;
            end
            if (err_timeout && err_rel < 0) err_rel = rel;
            if (rel == 2) begin snap_rd0 = rd_data[0]; snap_busy = busy; snap_ir = inputReady; end
            if (rel == start2_at) begin
                start = 1'b1; load_vld = 1'b1; load_col = '0; load_data = '{default: 64'hDEAD};
            end
            if (rel == inj_at) begin inj_vld = 1'b1; inj_norm = '{default: 64'h77}; end
        end
    endtask

    col_t v, expc;
    col_t zero_col;
    col_t ones_col;
    int   cnt_a, cnt_b;

    initial begin
        tbl[0] = '{col: 0, base: 64'h1000, exp_issue: 1};
        tbl[1] = '{col: 1, base: 64'h2000, exp_issue: 1 + (L + 1)};
        tbl[2] = '{col: 2, base: 64'h3000, exp_issue: 1 + 2 * (L + 1)};
        tbl[3] = '{col: 3, base: 64'h4000, exp_issue: 1 + 3 * (L + 1)};
        tbl[4] = '{col: 4, base: 64'hFFFF, exp_issue: -1};
        zero_col = '{default: 64'h0};
        ones_col = '{default: {64{1'b1}}};

        reset = 1'b1; load_vld = 1'b0; load_col = '0; load_data = zero_col;
        start = 1'b0; rd_col = '0; inj_vld = 1'b0; inj_norm = zero_col;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ir", inputReady, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_opcnt", opCnt, 0);
        chk_col("rst_opcol", opColumn, zero_col);
        for (int c = 0; c < MS; c++) begin
            read_col(c, v);
            chk_col($sformatf("rst_bank%0d", c), v, zero_col);
        end

        // Main pass: load table (index 4 must be dropped), then sequence
        for (int i = 0; i < 5; i++) begin
            load_vld = 1'b1;
            load_col = CW'(tbl[i].col);
            for (int e = 0; e < MS; e++) load_data[e] = tbl[i].base + 64'(e);
            @(posedge clk); #1;
        end
        load_vld = 1'b0;
        run_pass(MS * (L + 1) + 6, -1, -1);
        chk("main_n_issue", 64'(n_issue), MS);
        for (int i = 0; i < MS; i++) begin
            chk($sformatf("main_issue_cyc%0d", i), 64'(issue_rel[i]), 64'(tbl[i].exp_issue));
            chk($sformatf("main_opcnt%0d", i), 64'(issue_cnt[i]), 64'(tbl[i].col));
            for (int e = 0; e < MS; e++) expc[e] = tbl[i].base + 64'(e);
            chk_col($sformatf("main_opcol%0d", i), issue_col[i], expc);
        end
        chk("main_n_done", 64'(n_done), 1);
        chk("main_done_cyc", 64'(done_rel), MS * (L + 1) + 1);
        chk("main_busy_first", 64'(busy_first), 1);
        chk("main_busy_last", 64'(busy_last), MS * (L + 1));
        for (int i = 0; i < MS; i++) begin
            read_col(tbl[i].col, v);
            for (int e = 0; e < MS; e++) expc[e] = ~(tbl[i].base + 64'(e));
            chk_col($sformatf("main_rd%0d", i), v, expc);
        end
        chk("main_opcol_hold", opColumn[0], tbl[3].base);

        // Reset during the column-1 WAIT
        run_pass(60, -1, -1);
        chk("pre_rst_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ir", inputReady, 0);
        chk("mid_rst_err", err_timeout, 0);
        chk("mid_rst_opcnt", opCnt, 0);
        chk_col("mid_rst_opcol", opColumn, zero_col);
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done) cnt_a++;
            if (busy) cnt_b++;
        end
        chk("post_rst_no_done", 64'(cnt_a), 0);
        chk("post_rst_no_busy", 64'(cnt_b), 0);
        for (int c = 0; c < MS; c++) begin
            read_col(c, v);
            chk_col($sformatf("post_rst_bank%0d", c), v, zero_col);
        end

        // start+load together, ISSUE-cycle outVld, mid-pass start/load ignored
        rd_col = '0;
        load_vld = 1'b1; load_col = CW'(2); load_data = '{default: 64'hA5};
        run_pass(MS * (L + 1) + 6, 50, 1);
        chk("coinc_opcol2", issue_col[2][0], 64'hA5);
        chk("coinc_opcnt2", 64'(issue_cnt[2]), 2);
        chk("issue_vld_bank0", snap_rd0, 64'h0);
        chk("issue_vld_busy", snap_busy, 1);
        chk("issue_vld_ir", snap_ir, 0);
        chk("coinc_n_issue", 64'(n_issue), MS);
        chk("coinc_n_done", 64'(n_done), 1);
        chk("coinc_done_cyc", 64'(done_rel), MS * (L + 1) + 1);
        read_col(0, v);
        chk_col("coinc_rd0", v, ones_col);
        read_col(2, v);
        for (int e = 0; e < MS; e++) expc[e] = ~64'hA5;
        chk_col("coinc_rd2", v, expc);

        // outVld while IDLE
        inj_vld = 1'b1; inj_norm = '{default: 64'h1234};
        @(posedge clk); #1;
        inj_vld = 1'b0;
        chk("idle_vld_busy", busy, 0);
        chk("idle_vld_done", done, 0);
        read_col(0, v);
        chk_col("idle_vld_rd0", v, ones_col);

`ifdef MAT_SEQ_TIMEOUT_EN
        drop_col = 1;
        run_pass(130, -1, -1);
        drop_col = -1;
        chk("to_err_cyc", 64'(err_rel), 40 + 64);
        chk("to_err", err_timeout, 1);
        chk("to_busy", busy, 0);
        chk("to_n_done", 64'(n_done), 0);
        read_col(0, v);
        chk_col("to_rd0", v, zero_col);
        read_col(1, v);
        chk_col("to_rd1", v, ones_col);
        run_pass(3, -1, -1);
        chk("to_err_cleared", err_timeout, 0);
`else
        slow_col = 3; slow_extra = 500;
        run_pass(MS * (L + 1) + 510, -1, -1);
        slow_col = -1;
        chk("slow_err_rel", 64'(err_rel), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("slow_n_done", 64'(n_done), 1);
        chk("slow_done_cyc", 64'(done_rel), MS * (L + 1) + 1 + 500);
        read_col(3, v);
        chk_col("slow_rd3", v, zero_col);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
